am_scan_ctrl: RTL and testbench

Seek/scan controller for the 1-bit AM receiver chain. It steps the NCO phase increment across a programmable channel grid and flushes the CIC decimators after each retune. For each channel it waits for the chain to settle, then averages the AM demodulator output magnitude. At the end of the scan it tunes the NCO to the strongest channel. It sits between the host/config logic and `nco_sq` (drives `phase_inc`), and it consumes the `am_demod_lite` sample stream and tick.

---
 rtl/am_scan_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_am_scan_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/am_scan_ctrl.sv
// am_scan_ctrl: seek/scan controller that steps the NCO across a channel grid and locks to the strongest channel.
// Optional squelch feature enabled by defining AM_SCAN_SQUELCH_EN.
module am_scan_ctrl #(
  parameter int PHASE_W      = 26,
  parameter int CH_W         = 7,
  parameter int SETTLE_TICKS = 16,
  parameter int MEAS_LOG2    = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic               abort,
  input  logic [PHASE_W-1:0] base_inc,
  input  logic [PHASE_W-1:0] step_inc,
  input  logic [CH_W-1:0]    num_ch,
  input  logic [PHASE_W-1:0] manual_inc,
  input  logic               manual_load,
  input  logic               sample_tick,
  input  logic [15:0]        sample_in,
`ifdef AM_SCAN_SQUELCH_EN
  input  logic [15:0]        squelch_lvl,
  output logic               no_signal,
`endif
  output logic [PHASE_W-1:0] phase_inc,
  output logic               flush,
  output logic               busy,
  output logic               done,
  output logic [CH_W-1:0]    best_ch,
  output logic [15:0]        best_level
);

  localparam int ACC_W   = 16 + MEAS_LOG2;
  localparam int MEAS_N  = 1 << MEAS_LOG2;
  localparam int CNT_MAX = (SETTLE_TICKS > MEAS_N) ? SETTLE_TICKS : MEAS_N;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);
  localparam logic [CNT_W-1:0] MEAS_LAST   = CNT_W'(MEAS_N - 1);

  typedef enum logic [2:0] {
    IDLE,
    TUNE,
    SETTLE,
    MEASURE,
    COMPARE,
    LOCK
  } state_t;

  state_t             state, state_nxt;
  logic [PHASE_W-1:0] phase_inc_nxt;
  logic               flush_nxt;
  logic               busy_nxt;
  logic               done_nxt;
  logic [CH_W-1:0]    best_ch_nxt;
  logic [15:0]        best_level_nxt;
  logic [CH_W-1:0]    cur_ch, cur_ch_nxt;
  logic [PHASE_W-1:0] cur_inc, cur_inc_nxt;
  logic [PHASE_W-1:0] best_inc, best_inc_nxt;
  logic [PHASE_W-1:0] saved_inc, saved_inc_nxt;
  logic [CNT_W-1:0]   tick_cnt, tick_cnt_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic [15:0]        lvl;
  logic               last_ch;
  logic               squelched;
  logic [PHASE_W-1:0] lock_inc;
`ifdef AM_SCAN_SQUELCH_EN
  logic               no_signal_nxt;
`endif

  // The accumulator holds exactly 2^MEAS_LOG2 samples, so the mean is its top 16 bits.
  assign lvl     = acc[ACC_W-1:MEAS_LOG2];
  assign last_ch = (cur_ch == (num_ch - CH_W'(1)));

`ifdef AM_SCAN_SQUELCH_EN
  assign squelched = (best_level < squelch_lvl);
`else
  assign squelched = 1'b0;
`endif
  assign lock_inc = squelched ? saved_inc : best_inc;

  always_comb begin
    state_nxt      = state;
    phase_inc_nxt  = phase_inc;
    flush_nxt      = 1'b0;
    done_nxt       = 1'b0;
    best_ch_nxt    = best_ch;
    best_level_nxt = best_level;
    cur_ch_nxt     = cur_ch;
    cur_inc_nxt    = cur_inc;
    best_inc_nxt   = best_inc;
    saved_inc_nxt  = saved_inc;
    tick_cnt_nxt   = tick_cnt;
    acc_nxt        = acc;
`ifdef AM_SCAN_SQUELCH_EN
    no_signal_nxt  = no_signal;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          if (num_ch == '0) begin
            done_nxt = 1'b1;
          end else begin
            saved_inc_nxt  = phase_inc;
            cur_ch_nxt     = '0;
            cur_inc_nxt    = base_inc;
            best_inc_nxt   = base_inc;
            best_ch_nxt    = '0;
            best_level_nxt = '0;
`ifdef AM_SCAN_SQUELCH_EN
            no_signal_nxt  = 1'b0;
`endif
            state_nxt      = TUNE;
          end
        end else if (manual_load) begin
          phase_inc_nxt = manual_inc;
          flush_nxt     = 1'b1;
        end
      end

      TUNE: begin
        phase_inc_nxt = cur_inc;
        flush_nxt     = 1'b1;
        tick_cnt_nxt  = '0;
        state_nxt     = SETTLE;
      end

      SETTLE: begin
        if (sample_tick) begin
          if (tick_cnt == SETTLE_LAST) begin
            tick_cnt_nxt = '0;
            acc_nxt      = '0;
            state_nxt    = MEASURE;
          end else begin
            tick_cnt_nxt = tick_cnt + CNT_W'(1);
          end
        end
      end

      MEASURE: begin
        if (sample_tick) begin
          acc_nxt = acc + ACC_W'(sample_in);
          if (tick_cnt == MEAS_LAST) begin
            state_nxt = COMPARE;
          end else begin
            tick_cnt_nxt = tick_cnt + CNT_W'(1);
          end
        end
      end

      COMPARE: begin
        // Strict compare keeps the lowest-index channel on ties.
        if (lvl > best_level) begin
          best_level_nxt = lvl;
          best_ch_nxt    = cur_ch;
          best_inc_nxt   = cur_inc;
        end
        if (last_ch) begin
          state_nxt = LOCK;
        end else begin
          cur_ch_nxt  = cur_ch + CH_W'(1);
          cur_inc_nxt = cur_inc + step_inc;
          state_nxt   = TUNE;
        end
      end

      LOCK: begin
        phase_inc_nxt = lock_inc;
        flush_nxt     = 1'b1;
        done_nxt      = 1'b1;
`ifdef AM_SCAN_SQUELCH_EN
        no_signal_nxt = squelched;
`endif
        state_nxt     = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Abort overrides whatever the active state wanted and restores the pre-scan tuning.
    if ((state != IDLE) && abort) begin
      state_nxt      = IDLE;
      phase_inc_nxt  = saved_inc;
      flush_nxt      = 1'b1;
      done_nxt       = 1'b0;
      best_ch_nxt    = best_ch;
      best_level_nxt = best_level;
      best_inc_nxt   = best_inc;
`ifdef AM_SCAN_SQUELCH_EN
      no_signal_nxt  = no_signal;
`endif
    end

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      phase_inc  <= '0;
      flush      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      best_ch    <= '0;
      best_level <= '0;
      cur_ch     <= '0;
      cur_inc    <= '0;
      best_inc   <= '0;
      saved_inc  <= '0;
      tick_cnt   <= '0;
      acc        <= '0;
`ifdef AM_SCAN_SQUELCH_EN
      no_signal  <= 1'b0;
`endif
    end else begin
      phase_inc  <= phase_inc_nxt;
      flush      <= flush_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      best_ch    <= best_ch_nxt;
      best_level <= best_level_nxt;
      cur_ch     <= cur_ch_nxt;
      cur_inc    <= cur_inc_nxt;
      best_inc   <= best_inc_nxt;
      saved_inc  <= saved_inc_nxt;
      tick_cnt   <= tick_cnt_nxt;
      acc        <= acc_nxt;
`ifdef AM_SCAN_SQUELCH_EN
      no_signal  <= no_signal_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_am_scan_ctrl.sv
// Testbench for am_scan_ctrl: directed and random scans checked against a channel-level reference model.
// Exercises the squelch path too when AM_SCAN_SQUELCH_EN is defined.
module tb_am_scan_ctrl;

  localparam int PW = 26;
  localparam int CW = 7;
  localparam int S  = 4;
  localparam int M  = 2;
  localparam int N  = 1 << M;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [PW-1:0] base_inc = '0;
  logic [PW-1:0] step_inc = '0;
  logic [CW-1:0] num_ch = '0;
  logic [PW-1:0] manual_inc = '0;
  logic          manual_load = 1'b0;
  logic          sample_tick = 1'b0;
  logic [15:0]   sample_in = '0;
  logic [PW-1:0] phase_inc;
  logic          flush;
  logic          busy;
  logic          done;
  logic [CW-1:0] best_ch;
  logic [15:0]   best_level;
`ifdef AM_SCAN_SQUELCH_EN
  logic [15:0]   squelch_lvl = '0;
  logic          no_signal;
`endif

  am_scan_ctrl #(
    .PHASE_W(PW), .CH_W(CW), .SETTLE_TICKS(S), .MEAS_LOG2(M)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort),
    .base_inc(base_inc), .step_inc(step_inc), .num_ch(num_ch),
    .manual_inc(manual_inc), .manual_load(manual_load),
    .sample_tick(sample_tick), .sample_in(sample_in),
`ifdef AM_SCAN_SQUELCH_EN
    .squelch_lvl(squelch_lvl), .no_signal(no_signal),
`endif
    .phase_inc(phase_inc), .flush(flush), .busy(busy), .done(done),
    .best_ch(best_ch), .best_level(best_level)
  );

  always #5 CLK = ~CLK;

  int            total = 0;
  int            bad = 0;
  bit            scan_active = 1'b0;
  bit            zero_pending = 1'b0;
  int            flush_idx = 0;
  int            sc_num = 0;
  logic [PW-1:0] sc_base = '0;
  logic [PW-1:0] sc_step = '0;
  logic [PW-1:0] exp_saved = '0;
  logic [PW-1:0] exp_idle_phase = '0;
  logic [PW-1:0] last_phase = '0;
  logic [15:0]   levels[$];
  logic [PW-1:0] flush_log[$];
  int            flush_cnt = 0;
  int            done_cnt = 0;
  int            m_cnt = S + N;
  longint        m_acc = 0;
  bit            const_mode = 1'b0;
  logic [15:0]   chan_val[8];
  int            tick_pct = 60;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] chan_inc(input int k);
    logic [PW-1:0] r;
    r = sc_base + PW'(k) * sc_step;
    return r;
  endfunction

  // Sample source: constant level per channel for directed tests, noise otherwise.
  always @(posedge CLK) begin
    #1;
    sample_tick = ($urandom_range(0, 99) < tick_pct);
    if (const_mode) sample_in = chan_val[(flush_idx > 0) ? ((flush_idx - 1) % 8) : 0];
    else sample_in = 16'($urandom);
  end

  // Channel-level model: after each retune, S ticks are dropped and the next N are averaged.
  always @(posedge CLK) begin
    if (!RST) begin
      if (flush) begin
        m_cnt = 0;
        m_acc = 0;
      end
      if (sample_tick && m_cnt < S + N) begin
        if (m_cnt >= S) m_acc += longint'(sample_in);
        m_cnt++;
        if (m_cnt == S + N && scan_active && flush_idx >= 1) levels.push_back(16'(m_acc / N));
      end
    end
  end

  // Compare process: every retune, lock and done pulse is checked against the model.
  always @(negedge CLK) begin
    int            bc;
    logic [15:0]   bl;
    logic [PW-1:0] lock;
    if (!RST) begin
      if (flush) begin
        flush_cnt++;
        flush_log.push_back(phase_inc);
        if (scan_active && flush_idx < sc_num) begin
          checkOutput("tune_inc", phase_inc, chan_inc(flush_idx));
          checkOutput("tune_no_done", done, 0);
          flush_idx++;
        end else if (scan_active) begin
          checkOutput("num_levels", levels.size(), sc_num);
          bc = 0;
          bl = '0;
          foreach (levels[k]) if (levels[k] > bl) begin bl = levels[k]; bc = k; end
          lock = chan_inc(bc);
`ifdef AM_SCAN_SQUELCH_EN
          if (bl < squelch_lvl) lock = exp_saved;
          checkOutput("no_signal", no_signal, (bl < squelch_lvl));
`endif
          checkOutput("lock_inc", phase_inc, lock);
          checkOutput("lock_done", done, 1);
          checkOutput("lock_best_ch", best_ch, bc);
          checkOutput("lock_best_level", best_level, bl);
          scan_active = 1'b0;
        end else begin
          checkOutput("idle_flush_inc", phase_inc, exp_idle_phase);
          checkOutput("idle_flush_no_done", done, 0);
        end
        last_phase = phase_inc;
      end else begin
        checkOutput("phase_hold", phase_inc, last_phase);
        if (done) begin
          checkOutput("done_expected", zero_pending, 1);
          zero_pending = 1'b0;
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulseManual(input logic [PW-1:0] v);
    exp_idle_phase = v;
    manual_inc = v;
    manual_load = 1'b1;
    tick(1);
    manual_load = 1'b0;
    checkOutput("manual_phase", phase_inc, v);
    checkOutput("manual_flush", flush, 1);
    tick(1);
    checkOutput("manual_flush_once", flush, 0);
  endtask

  task automatic applyStimulus(input int num, input logic [PW-1:0] base, input logic [PW-1:0] step,
                               input bit with_manual, input bit chk_timing);
    levels.delete();
    flush_idx = 0;
    sc_num = num;
    sc_base = base;
    sc_step = step;
    exp_saved = last_phase;
    exp_idle_phase = last_phase;
    scan_active = (num != 0);
    zero_pending = (num == 0);
    num_ch = CW'(num);
    base_inc = base;
    step_inc = step;
    start = 1'b1;
    if (with_manual) begin
      manual_load = 1'b1;
      manual_inc = ~base;
    end
    tick(1);
    start = 1'b0;
    manual_load = 1'b0;
    if (chk_timing) begin
      checkOutput("start_busy", busy, 1);
      checkOutput("start_flush_early", flush, 0);
      checkOutput("start_phase_hold", phase_inc, exp_saved);
      tick(1);
      checkOutput("tune_flush", flush, 1);
      checkOutput("tune_phase", phase_inc, base);
    end
  endtask

  task automatic waitScanEnd();
    for (int i = 0; i < 4000 && scan_active; i++) tick(1);
    if (scan_active) begin
      total++;
      bad++;
      $display("[TB] FAIL scan_timeout: got=busy expected=done");
      scan_active = 1'b0;
    end
    tick(2);
  endtask

  task automatic waitIdx(input int k);
    int i;
    for (i = 0; i < 4000 && flush_idx < k; i++) tick(1);
    if (flush_idx < k) begin
      total++;
      bad++;
      $display("[TB] FAIL idx_timeout: got=%0d expected=%0d", flush_idx, k);
    end
  endtask

  task automatic modelReset();
    scan_active = 1'b0;
    zero_pending = 1'b0;
    last_phase = '0;
    exp_idle_phase = '0;
    m_cnt = S + N;
    levels.delete();
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_phase"}, phase_inc, 0);
    checkOutput({tag, "_flush"}, flush, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_best_ch"}, best_ch, 0);
    checkOutput({tag, "_best_level"}, best_level, 0);
`ifdef AM_SCAN_SQUELCH_EN
    checkOutput({tag, "_no_signal"}, no_signal, 0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fc0, dc0;
    logic [PW-1:0] p0;
    for (int i = 0; i < 8; i++) chan_val[i] = '0;

    tick(3);
    checkZero("reset");
    #2 RST = 1'b0;
    tick(1);

    $display("[TB] reset during scan");
    const_mode = 1'b1;
    chan_val[0] = 16'd100; chan_val[1] = 16'd500; chan_val[2] = 16'd300;
    applyStimulus(3, 26'h90000, 26'h1000, 1'b0, 1'b1);
    waitIdx(2);
    checkOutput("pre_reset_level", best_level, 100);
    #2 RST = 1'b1;
    modelReset();
    #1 checkZero("midscan_reset");
    tick(2);
    #2 RST = 1'b0;
    tick(1);
    checkZero("after_reset");

    $display("[TB] manual load");
    pulseManual(26'h995aa);

    $display("[TB] three channel scan");
    fc0 = flush_cnt;
    dc0 = done_cnt;
    applyStimulus(3, 26'h90000, 26'h1000, 1'b0, 1'b1);
    waitScanEnd();
    checkOutput("scan3_best_ch", best_ch, 1);
    checkOutput("scan3_best_level", best_level, 500);
    checkOutput("scan3_phase", phase_inc, 26'h91000);
    checkOutput("scan3_flushes", flush_cnt - fc0, 4);
    checkOutput("scan3_dones", done_cnt - dc0, 1);
    checkOutput("scan3_seq0", flush_log[fc0], 26'h90000);
    checkOutput("scan3_seq1", flush_log[fc0 + 1], 26'h91000);
    checkOutput("scan3_seq2", flush_log[fc0 + 2], 26'h92000);
    checkOutput("scan3_busy", busy, 0);

    $display("[TB] tie");
    chan_val[0] = 16'd200; chan_val[1] = 16'd200;
    applyStimulus(2, 26'h50000, 26'h800, 1'b0, 1'b0);
    waitScanEnd();
    checkOutput("tie_best_ch", best_ch, 0);
    checkOutput("tie_best_level", best_level, 200);

    $display("[TB] all zero");
    chan_val[0] = '0; chan_val[1] = '0; chan_val[2] = '0;
    applyStimulus(3, 26'h123456, 26'h1000, 1'b0, 1'b0);
    waitScanEnd();
    checkOutput("zero_best_ch", best_ch, 0);
    checkOutput("zero_phase", phase_inc, 26'h123456);

    $display("[TB] abort");
    pulseManual(26'h995aa);
    chan_val[0] = 16'd100; chan_val[1] = 16'd500; chan_val[2] = 16'd300;
    applyStimulus(3, 26'h90000, 26'h1000, 1'b0, 1'b0);
    waitIdx(1);
    tick(3);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    waitIdx(2);
    for (int i = 0; i < 2000 && !(m_cnt > S && m_cnt < S + N); i++) tick(1);
    dc0 = done_cnt;
    scan_active = 1'b0;
    exp_idle_phase = 26'h995aa;
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    checkOutput("abort_flush", flush, 1);
    checkOutput("abort_phase", phase_inc, 26'h995aa);
    checkOutput("abort_busy", busy, 0);
    tick(3);
    checkOutput("abort_no_done", done_cnt - dc0, 0);
    checkOutput("abort_best_ch", best_ch, 0);
    checkOutput("abort_best_level", best_level, 100);

    $display("[TB] wrap with simultaneous manual load");
    const_mode = 1'b0;
    fc0 = flush_cnt;
    applyStimulus(2, 26'h3FFF000, 26'h2000, 1'b1, 1'b1);
    waitScanEnd();
    checkOutput("wrap_ch0", flush_log[fc0], 26'h3FFF000);
    checkOutput("wrap_ch1", flush_log[fc0 + 1], 26'h0001000);

    $display("[TB] zero channels and idle abort");
    p0 = phase_inc;
    fc0 = flush_cnt;
    applyStimulus(0, 26'h777, 26'h1, 1'b0, 1'b0);
    checkOutput("nch0_done", done, 1);
    checkOutput("nch0_busy", busy, 0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    checkOutput("nch0_done_once", done, 0);
    checkOutput("idle_abort_flush", flush, 0);
    checkOutput("nch0_phase", phase_inc, p0);
    checkOutput("nch0_flushes", flush_cnt - fc0, 0);

    $display("[TB] random scans");
    for (int r = 0; r < 8; r++) begin
      tick_pct = $urandom_range(25, 100);
`ifdef AM_SCAN_SQUELCH_EN
      squelch_lvl = 16'($urandom);
`endif
      applyStimulus($urandom_range(1, 5), PW'($urandom), PW'($urandom), 1'b0, 1'b1);
      waitScanEnd();
    end
    tick_pct = 60;

`ifdef AM_SCAN_SQUELCH_EN
    $display("[TB] squelch");
    pulseManual(26'h2222);
    const_mode = 1'b1;
    chan_val[0] = 16'd100; chan_val[1] = 16'd500; chan_val[2] = 16'd300;
    squelch_lvl = 16'd600;
    applyStimulus(3, 26'h90000, 26'h1000, 1'b0, 1'b0);
    waitScanEnd();
    checkOutput("sq_phase", phase_inc, 26'h2222);
    checkOutput("sq_no_signal", no_signal, 1);
    checkOutput("sq_best_level", best_level, 500);
    squelch_lvl = 16'd400;
    applyStimulus(3, 26'h90000, 26'h1000, 1'b0, 1'b0);
    waitScanEnd();
    checkOutput("sq2_phase", phase_inc, 26'h91000);
    checkOutput("sq2_no_signal", no_signal, 0);
`endif

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
